// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard / control-flow arbiter.
// Picks at most one control event per cycle (branch, halt, exception, RTI,
// jump, load-use), drives fetch/decode hold and kill controls combinationally,
// and keeps the exception return PC, in-exception flag, halt state and a
// saturating load-use stall counter.
module pipe_ctrl #(
  parameter logic [15:0] EXC_VECTOR = 16'h0002,
  parameter int          PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pc_p1,
  input  logic              halt_idif_p1,
  input  logic              illegal_op_idif_p1,
  input  logic              return_execution_idif_p1,
  input  logic              jmp_displacement_idif_p1,
  input  logic [15:0]       jmp_displacement_value_idif_p1,
  input  logic              branch_taken_ixif_p1,
  input  logic [15:0]       branch_target_ixif_p1,
  input  logic [2:0]        rs_idix_p1,
  input  logic [2:0]        rt_idix_p1,
  input  logic              rs_used_p1,
  input  logic              rt_used_p1,
  input  logic              ldst_valid_ix_p1,
  input  logic [2:0]        ld_rd_ix_p1,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idix_bubble,
  output logic              redirect_valid,
  output logic [15:0]       redirect_pc,
  output logic [15:0]       epc_p1,
  output logic              in_exc,
  output logic              halted,
  output logic [PERF_W-1:0] stall_cnt
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Exactly one of these is acted on per cycle; nested exception and RTI
  // outside an exception both collapse into EV_HALT.
  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_BRANCH = 3'd1,
    EV_HALT   = 3'd2,
    EV_EXC    = 3'd3,
    EV_RTI    = 3'd4,
    EV_JUMP   = 3'd5,
    EV_LDUSE  = 3'd6
  } event_t;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    if (&v) return v;
    return v + {{(PERF_W-1){1'b0}}, 1'b1};
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  event_t              w_event;
  logic [15:0]         r_epc;
  logic                r_in_exc;
  logic [PERF_W-1:0]   r_stall_cnt;
  logic                w_load_use;
  logic [15:0]         w_jump_target;
  logic [15:0]         w_pc_next_seq;

  assign w_pc_next_seq = pc_p1 + 16'd2;
  assign w_jump_target = w_pc_next_seq + jmp_displacement_value_idif_p1;
  assign w_load_use    = ldst_valid_ix_p1 &
                         ((rs_used_p1 & (rs_idix_p1 == ld_rd_ix_p1)) |
                          (rt_used_p1 & (rt_idix_p1 == ld_rd_ix_p1)));

  // Priority select of the single event acted on this cycle (RUN only, not in reset).
  always_comb begin
    w_event = EV_NONE;
    if (!rst && r_state == ST_RUN) begin
      if (branch_taken_ixif_p1)          w_event = EV_BRANCH;
      else if (halt_idif_p1)             w_event = EV_HALT;
      else if (illegal_op_idif_p1)       w_event = r_in_exc ? EV_HALT : EV_EXC;
      else if (return_execution_idif_p1) w_event = r_in_exc ? EV_RTI : EV_HALT;
      else if (jmp_displacement_idif_p1) w_event = EV_JUMP;
      else if (w_load_use)               w_event = EV_LDUSE;
    end
  end

  // State register: HALTED is left only through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_RUN && w_event == EV_HALT) w_state_nxt = ST_HALTED;
  end

  // Output logic: same-cycle controls from state and selected event.
  always_comb begin
    pc_stall       = 1'b0;
    ifid_stall     = 1'b0;
    ifid_flush     = 1'b0;
    idix_bubble    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    halted         = 1'b0;
    if (!rst && r_state == ST_HALTED) begin
      pc_stall   = 1'b1;
      ifid_flush = 1'b1;
      halted     = 1'b1;
    end
    case (w_event)
      EV_BRANCH: begin
        redirect_valid = 1'b1;
        redirect_pc    = branch_target_ixif_p1;
        ifid_flush     = 1'b1;
        idix_bubble    = 1'b1;
      end
      EV_HALT: begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
      end
      EV_EXC: begin
        redirect_valid = 1'b1;
        redirect_pc    = EXC_VECTOR;
        ifid_flush     = 1'b1;
      end
      EV_RTI: begin
        redirect_valid = 1'b1;
        redirect_pc    = r_epc;
        ifid_flush     = 1'b1;
      end
      EV_JUMP: begin
        redirect_valid = 1'b1;
        redirect_pc    = w_jump_target;
        ifid_flush     = 1'b1;
      end
      EV_LDUSE: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idix_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Exception context: capture return PC on entry, clear the flag on RTI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_epc    <= 16'h0000;
      r_in_exc <= 1'b0;
    end else if (w_event == EV_EXC) begin
      r_epc    <= w_pc_next_seq;
      r_in_exc <= 1'b1;
    end else if (w_event == EV_RTI) begin
      r_in_exc <= 1'b0;
    end
  end

  // Load-use stall counter, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_stall_cnt <= '0;
    else if (w_event == EV_LDUSE) r_stall_cnt <= sat_inc(r_stall_cnt);
  end

  assign epc_p1    = r_epc;
  assign in_exc    = r_in_exc;
  assign stall_cnt = r_stall_cnt;

endmodule
